// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encode/issue block.
//   - opcode constants (3 bits), word/field widths
//   - issue FSM state enum
//   - request struct {op, fields, imm8} as stored in the request FIFO
//   - encode_word(): maps (state, request) to {lireg, instr}
package instr_pkg;

    localparam int INSTR_W = 8;
    localparam int FIELD_W = 5;
    localparam int OP_W    = 3;
    localparam int IMM_W   = 8;

    localparam logic [OP_W-1:0] OP_LI   = 3'b000;
    localparam logic [OP_W-1:0] OP_LW   = 3'b001;
    localparam logic [OP_W-1:0] OP_SW   = 3'b010;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b011;
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b100;
    localparam logic [OP_W-1:0] OP_SLTI = 3'b101;
    localparam logic [OP_W-1:0] OP_RR   = 3'b110;
    localparam logic [OP_W-1:0] OP_J    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_LI_HI = 2'd2,
        S_LI_LO = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FIELD_W-1:0] fields;
        logic [IMM_W-1:0]   imm8;
    } req_t;

    // Returns {lireg, instr}. A li request becomes a lui/lli pair: both halves
    // carry rt (fields[4]) and one nibble of the immediate under opcode 000.
    function automatic logic [INSTR_W:0] encode_word(input state_t st, input req_t r);
        logic [INSTR_W:0] w;
        case (st)
            S_ISSUE: w = {1'b0, r.op, r.fields};
            S_LI_HI: w = {1'b0, OP_LI, r.fields[4], r.imm8[7:4]};
            S_LI_LO: w = {1'b1, OP_LI, r.fields[4], r.imm8[3:0]};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Request FIFO for instr_encode_issue.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear of pointers and count
//   push, wdata  : write one request (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head         : entry at the read pointer
//   head_next    : entry behind the head, used to reload the issuer without a bubble
//   count        : occupancy, 0..DEPTH
module req_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  req_t                   wdata,
    input  logic                   pop,
    output req_t                   head,
    output req_t                   head_next,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    req_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           empty;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/instr_encode_issue.sv
// Producer side of the 8-bit control-decode interface.
// Buffers symbolic requests in a FIFO, encodes them into 8-bit words and
// issues them over a valid/ready port; li expands into a lui/lli pair.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/req_ready     : request handshake (ready = FIFO not full)
//   req_op/fields/imm8      : request payload
//   flush                   : drop everything pending, including a half-sent li
//   instr_valid/instr_ready : issue handshake
//   instr, lireg            : encoded word; lireg=1 marks the lli half
//   fifo_count              : FIFO occupancy
//   issued_cnt              : words issued (only with ISSUE_CNT_EN defined)
// Optional feature macro: ISSUE_CNT_EN.
module instr_encode_issue
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OP_W-1:0]        req_op,
    input  logic [FIELD_W-1:0]     req_fields,
    input  logic [IMM_W-1:0]       req_imm8,
    input  logic                   flush,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_W-1:0]     instr,
    output logic                   lireg,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef ISSUE_CNT_EN
    ,
    output logic [CNT_W-1:0]       issued_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t state, state_nxt;
    req_t   cur, cur_nxt;       // request currently being issued (still in the FIFO)
    req_t   req_in, head, head_next, src;
    logic   push, pop, hs, load;

    assign req_in    = '{op: req_op, fields: req_fields, imm8: req_imm8};
    // Ready depends on occupancy only, so a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    assign req_ready = (fifo_count != CW'(DEPTH));
    assign push      = req_valid && req_ready && !flush;
    assign hs        = instr_valid && instr_ready;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .wdata     (req_in),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // The entry being issued stays at the FIFO head until its last word is
    // accepted. On that pop the next request is either the entry behind the
    // head or, if the FIFO is about to be empty, the one arriving right now.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        pop       = 1'b0;
        load      = 1'b0;
        src       = head;
        unique case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    load = 1'b1;
                    src  = head;
                end else if (push) begin
                    load = 1'b1;
                    src  = req_in;
                end
            end
            S_ISSUE, S_LI_LO: begin
                if (hs) begin
                    pop = 1'b1;
                    if (fifo_count > CW'(1)) begin
                        load = 1'b1;
                        src  = head_next;
                    end else if (push) begin
                        load = 1'b1;
                        src  = req_in;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_LI_HI: begin
                if (hs) state_nxt = S_LI_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (load) begin
            cur_nxt   = src;
            state_nxt = (src.op == OP_LI) ? S_LI_HI : S_ISSUE;
        end
        if (flush) begin
            state_nxt = S_IDLE;
            pop       = 1'b0;
        end
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        instr_valid    = (state != S_IDLE);
        {lireg, instr} = encode_word(state, cur);
    end

`ifdef ISSUE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issued_cnt <= '0;
        else if (hs && !flush)
            issued_cnt <= issued_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_instr_encode_issue.sv
module tb_instr_encode_issue;
    typedef logic [8:0] word_t;   // {lireg, instr}

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = '0;
    logic [4:0] req_fields = '0;
    logic [7:0] req_imm8 = '0;
    logic       flush = 1'b0;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr;
    logic       lireg;
    logic [2:0] fifo_count;
`ifdef ISSUE_CNT_EN
    logic [15:0] issued_cnt;
`endif

    int errors = 0;
    int checks = 0;

    word_t exp_q[$];
    word_t obs [0:1023];
    int    obs_cyc [0:1023];
    int    obs_n = 0;
    int    rd_idx = 0;
    int    cyc = 0;

    always #5 clk = ~clk;

    instr_encode_issue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_fields  (req_fields),
        .req_imm8    (req_imm8),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .lireg       (lireg),
        .fifo_count  (fifo_count)
`ifdef ISSUE_CNT_EN
        ,
        .issued_cnt  (issued_cnt)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted output word with the cycle it was taken in.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && obs_n < 1024) begin
            obs[obs_n]     <= {lireg, instr};
            obs_cyc[obs_n] <= cyc;
            obs_n          <= obs_n + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [4:0] f, input logic [7:0] imm);
        if (op == 3'b000) begin
            exp_q.push_back({1'b0, 3'b000, f[4], imm[7:4]});
            exp_q.push_back({1'b1, 3'b000, f[4], imm[3:0]});
        end else begin
            exp_q.push_back({1'b0, op, f});
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] f, input logic [7:0] imm);
        req_valid  = 1'b1;
        req_op     = op;
        req_fields = f;
        req_imm8   = imm;
        push_exp(op, f, imm);
        tick;
        req_valid = 1'b0;
    endtask

    // Waits (bounded) until the monitor has as many words as are expected.
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (obs_n - rd_idx >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h expected 00", instr); end
        checks++; if (lireg !== 1'b0) begin errors++; $display("FAIL reset_lireg: got %b expected 0", lireg); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_single_addi;
        bit ok;
        word_t e;
        instr_ready = 1'b1;
        send(3'b011, 5'b10110, 8'h00);
        checks++; if (instr_valid !== 1'b1 || {lireg, instr} !== 9'h076) begin
            errors++; $display("FAIL addi_latency: got v=%b %h expected v=1 076", instr_valid, {lireg, instr}); end
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL addi_drop: got valid %b expected 0", instr_valid); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL addi_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL addi_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
    endtask

    task automatic test_li_hold;
        bit ok;
        word_t e;
        instr_ready = 1'b0;
        send(3'b000, 5'b10000, 8'hA5);
        send(3'b011, 5'b00001, 8'hFF);
        checks++; if (instr_valid !== 1'b1 || {lireg, instr} !== 9'h01A) begin
            errors++; $display("FAIL li_hi: got v=%b %h expected v=1 01A", instr_valid, {lireg, instr}); end
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr_valid !== 1'b1 || {lireg, instr} !== 9'h115) begin
                errors++; $display("FAIL li_lo_hold: got v=%b %h expected v=1 115", instr_valid, {lireg, instr}); end
            tick;
        end
        instr_ready = 1'b1;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL li_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL li_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
    endtask

    task automatic test_fill;
        bit ok;
        word_t e;
        int base, bubbles;
        instr_ready = 1'b0;
        send(3'b001, 5'd1, 8'h00);
        send(3'b010, 5'd2, 8'h00);
        send(3'b100, 5'd3, 8'h00);
        send(3'b111, 5'd31, 8'h00);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", fifo_count); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", req_ready); end
        req_valid = 1'b1; req_op = 3'b110; req_fields = 5'd9;
        tick;
        req_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_refuse: got %0d expected 4", fifo_count); end
        base = rd_idx;
        instr_ready = 1'b1;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        bubbles = 0;
        for (int k = base + 1; k < base + 4 && k < obs_n; k++)
            if (obs_cyc[k] != obs_cyc[k-1] + 1) bubbles++;
        checks++; if (bubbles != 0) begin errors++; $display("FAIL fill_bubbles: got %0d expected 0", bubbles); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL fill_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
    endtask

    task automatic test_flush;
        bit ok;
        word_t e;
        instr_ready = 1'b0;
        send(3'b000, 5'b00000, 8'h5A);
        send(3'b011, 5'd4, 8'h00);
        send(3'b111, 5'd7, 8'h00);
        exp_q.delete();
        checks++; if (instr_valid !== 1'b1 || {lireg, instr} !== 9'h005 || fifo_count !== 3'd3) begin
            errors++; $display("FAIL flush_pre: got v=%b %h n=%0d expected v=1 005 n=3", instr_valid, {lireg, instr}, fifo_count); end
        flush = 1'b1;
        req_valid = 1'b1; req_op = 3'b011; req_fields = 5'd1;
        tick;
        flush = 1'b0;
        req_valid = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", instr_valid); end
        rd_idx = obs_n;
        instr_ready = 1'b1;
        send(3'b000, 5'b10000, 8'h3C);
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL flush_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        word_t e;
        int sent;
        logic [2:0] op;
        logic [4:0] f;
        logic [7:0] imm;
        sent = 0;
        for (int c = 0; c < 300 && sent < 16; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            if (req_ready) begin
                op  = 3'($urandom_range(0, 7));
                f   = 5'($urandom_range(0, 31));
                imm = 8'($urandom_range(0, 255));
                req_valid = 1'b1; req_op = op; req_fields = f; req_imm8 = imm;
                push_exp(op, f, imm);
                sent++;
            end else begin
                req_valid = 1'b0;
            end
            tick;
        end
        req_valid = 1'b0;
        instr_ready = 1'b1;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL b2b_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
    endtask

    task automatic test_reset_mid;
        instr_ready = 1'b0;
        send(3'b000, 5'b10000, 8'hA5);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        checks++; if (lireg !== 1'b1 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got v=%b lireg=%b expected v=1 lireg=1", instr_valid, lireg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || lireg !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL rstmid_async: got v=%b lireg=%b n=%0d expected v=0 lireg=0 n=0", instr_valid, lireg, fifo_count); end
        exp_q.delete();
        tick;
        rst_n = 1'b1;
        tick;
        rd_idx = obs_n;
    endtask

`ifdef ISSUE_CNT_EN
    task automatic test_issue_cnt;
        bit ok;
        word_t e;
        instr_ready = 1'b1;
        send(3'b011, 5'd5, 8'h00);
        send(3'b000, 5'b10000, 8'h81);
        send(3'b111, 5'd2, 8'h00);
        drain(ok);
        tick;
        checks++; if (!ok) begin errors++; $display("FAIL cnt_timeout: got %0d words expected %0d", obs_n - rd_idx, exp_q.size()); end
        while (exp_q.size() > 0 && rd_idx < obs_n) begin
            e = exp_q.pop_front();
            checks++; if (obs[rd_idx] !== e) begin errors++; $display("FAIL cnt_stream: got %h expected %h", obs[rd_idx], e); end
            rd_idx++;
        end
        checks++; if (issued_cnt !== 16'd4) begin errors++; $display("FAIL issued_cnt: got %0d expected 4", issued_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_addi;
        test_li_hold;
        test_fill;
        test_flush;
        test_back_to_back;
        test_reset_mid;
`ifdef ISSUE_CNT_EN
        test_issue_cnt;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
